hls_run_sequencer: RTL

//   Sequencer for one HLS-generated kernel (clock/reset/start_port/done_port/return_port).

---
 rtl/hls_seq_pkg.sv | 18 +
 rtl/hls_run_sequencer_sat_counter.sv | 25 ++
 rtl/hls_run_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/hls_seq_pkg.sv
// Shared definitions for the HLS kernel run sequencer: sequencer states and
// default widths of the run/cycle counters and the kernel return value.
package hls_seq_pkg;

    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_RUNS_W     = 16;
    localparam int DEF_CYC_W      = 32;
    localparam int RET_W          = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KRST  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        FIN   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/hls_run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones instead of
// wrapping so long measurements never read back as small values.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hls_run_sequencer.sv
// Runs one HLS kernel N times per command: reset, start, wait for done,
// check the return value, with a per-run timeout and a status record.
module hls_run_sequencer
    import hls_seq_pkg::*;
#(
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int RUNS_W     = DEF_RUNS_W,
    parameter int CYC_W      = DEF_CYC_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [RUNS_W-1:0] cmd_runs,
    input  logic [CYC_W-1:0]  cmd_timeout,
    input  logic [RET_W-1:0]  cmd_expected,
    output logic              kernel_reset,
    output logic              kernel_start,
    input  logic              kernel_done,
    input  logic [RET_W-1:0]  kernel_return,
    output logic              result_valid,
    output logic [RET_W-1:0]  result_checksum,
    output logic              result_mismatch,
    output logic              result_timeout,
    output logic [RUNS_W-1:0] runs_done,
    output logic [CYC_W-1:0]  total_cycles
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    seq_state_t        r_state;
    seq_state_t        w_nextState;
    logic [RC_W-1:0]   r_rstCnt;
    logic [RUNS_W-1:0] r_runs;
    logic [RUNS_W-1:0] r_runsDone;
    logic [CYC_W-1:0]  r_timeout;
    logic [RET_W-1:0]  r_expected;
    logic [RET_W-1:0]  r_checksum;
    logic              r_mismatch;
    logic              r_timedOut;

    logic              w_accept;
    logic              w_inWait;
    logic              w_done;
    logic              w_timeoutHit;
    logic              w_moreRuns;
    logic [RUNS_W:0]   w_nextRunsDone;
    logic [CYC_W-1:0]  w_runCycles;
    logic [CYC_W-1:0]  w_totalCycles;

    assign w_accept       = (r_state == IDLE) && cmd_valid;
    assign w_inWait       = (r_state == WAIT);
    assign w_done         = w_inWait && kernel_done;
    // The run counter holds completed WAIT cycles, so the limit is reached in the cycle it equals timeout-1.
    assign w_timeoutHit   = w_inWait && !kernel_done && (r_timeout != '0) &&
                            (w_runCycles == (r_timeout - CYC_W'(1)));
    assign w_nextRunsDone = {1'b0, r_runsDone} + (RUNS_W + 1)'(1);
    assign w_moreRuns     = w_nextRunsDone < {1'b0, r_runs};

    sat_counter #(.W(CYC_W)) u_runCounter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (r_state == START),
        .i_inc   (w_inWait),
        .o_count (w_runCycles)
    );

    sat_counter #(.W(CYC_W)) u_totalCounter (
        .clock   (clock),
        .reset   (reset),
        .i_clear (w_accept),
        .i_inc   (w_inWait),
        .o_count (w_totalCycles)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (r_state != KRST)) begin
            r_rstCnt <= '0;
        end else begin
            r_rstCnt <= r_rstCnt + RC_W'(1);
        end
    end

    always_comb begin
        w_nextState  = r_state;
        cmd_ready    = 1'b0;
        kernel_reset = 1'b1;
        kernel_start = 1'b0;
        result_valid = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_nextState = KRST;
                end
            end
            KRST: begin
                if (r_rstCnt == RC_W'(RST_CYCLES - 1)) begin
                    w_nextState = START;
                end
            end
            START: begin
                kernel_reset = 1'b0;
                kernel_start = 1'b1;
                w_nextState  = WAIT;
            end
            WAIT: begin
                kernel_reset = 1'b0;
                if (w_done) begin
                    w_nextState = w_moreRuns ? KRST : FIN;
                end else if (w_timeoutHit) begin
                    w_nextState = FIN;
                end
            end
            FIN: begin
                result_valid = 1'b1;
                w_nextState  = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Command latch and per-run status; results stay frozen from FIN until the next accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_runs     <= '0;
            r_timeout  <= '0;
            r_expected <= '0;
            r_checksum <= '0;
            r_mismatch <= 1'b0;
            r_timedOut <= 1'b0;
            r_runsDone <= '0;
        end else if (w_accept) begin
            r_runs     <= (cmd_runs == '0) ? RUNS_W'(1) : cmd_runs;
            r_timeout  <= cmd_timeout;
            r_expected <= cmd_expected;
            r_checksum <= '0;
            r_mismatch <= 1'b0;
            r_timedOut <= 1'b0;
            r_runsDone <= '0;
        end else if (w_done) begin
            r_checksum <= kernel_return;
            r_runsDone <= w_nextRunsDone[RUNS_W-1:0];
            if (kernel_return != r_expected) begin
                r_mismatch <= 1'b1;
            end
        end else if (w_timeoutHit) begin
            r_timedOut <= 1'b1;
        end
    end

    assign result_checksum = r_checksum;
    assign result_mismatch = r_mismatch;
    assign result_timeout  = r_timedOut;
    assign runs_done       = r_runsDone;
    assign total_cycles    = w_totalCycles;

endmodule
